led_p2s_shifter: RTL and testbench
==================================

Name: led_p2s_shifter

Overview:
- Parallel-to-serial shift engine that drives the board's external serial LED shift-register chain (74HC595-style).
- Consumes the parallel LED word produced by the SPIO output port stage and serialises it MSB-first with its own shift clock and latch pulse.
- Provides a Start/busy/done handshake to the SPIO stage.
- Sits directly downstream of SPIO, between it and the board pins.

Parameters:
- DATA_W, 16, bits per frame (must be >= 1).
- HALF, 2, system-clock cycles per half period of s_clk; also the s_pen pulse width (must be >= 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  frame request; sampled only in IDLE.
- P_Data  in  DATA_W  parallel word; captured on the accepting edge.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- s_clk  out  1  serial shift clock to the external chain; chain samples on its rising edge.
- s_data  out  1  serial data, MSB first.
- s_clrn  out  1  active-low clear to the external chain.
- s_pen  out  1  latch/output-enable pulse to the external chain.

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, busy=0, done=0, s_clk=0, s_data=0, s_pen=0, s_clrn=0 while rst=1.
  - s_clrn returns to 1 on the first clk edge after rst deasserts.
  - The shift register, bit counter and half counter are all cleared.
  - No partial latch pulse is produced.
- States: IDLE, LOW, HIGH, LATCH.
- IDLE:
  - Outputs s_clk=0, s_pen=0, busy=0.
  - Start=1 at edge E0 latches P_Data into sreg, sets bit_cnt=0 and half_cnt=0, and moves to LOW.
  - busy=1 from E0.
- LOW:
  - s_data=sreg[DATA_W-1], s_clk=0, held for HALF cycles, then move to HIGH.
- HIGH:
  - s_clk=1 for HALF cycles; s_data stays stable throughout.
  - On exit, sreg shifts left by one (zero fill) and bit_cnt increments.
  - If bit_cnt was DATA_W-1, move to LATCH; otherwise move to LOW.
- LATCH:
  - s_clk=0, s_data=0, s_pen=1 for HALF cycles, then move to IDLE.
- Timing, cycle-exact relative to E0:
  - Bit i low phase occupies cycles [2*HALF*i, 2*HALF*i+HALF).
  - Bit i high phase occupies cycles [2*HALF*i+HALF, 2*HALF*(i+1)).
  - LATCH occupies [2*HALF*DATA_W, 2*HALF*DATA_W+HALF).
  - At edge T=2*HALF*DATA_W+HALF: state=IDLE, busy=0, done=1 for exactly one cycle.
- Start handling:
  - Start while busy=1 is ignored; it is not queued.
  - Start=1 during the done cycle is accepted: back-to-back frames, with no gap beyond that one IDLE cycle.
- P_Data changes after E0 do not affect the current frame.
- All outputs are registered and glitch-free.
- Width rules:
  - half_cnt is $clog2(HALF) bits, minimum 1.
  - bit_cnt is $clog2(DATA_W) bits, minimum 1.
  - Counters must not wrap within a frame.

Decomposition:
- Shared package led_pkg:
  - State enum (IDLE, LOW, HIGH, LATCH).
  - Default constants LED_DATA_W=16 and LED_HALF=2, reused by SPIO when instantiating this block.
- One natural sub-module, led_half_tick:
  - Half-period counter with synchronous restart input.
  - Emits a one-cycle tick when HALF cycles have elapsed.
  - Same clk/rst.
- The FSM, shift register and bit counter stay in the top module.

Test Plan:
- HALF=2, DATA_W=16, P_Data=16'hA5C3, single Start pulse:
  - Exactly 16 s_clk rising edges.
  - Bits sampled there reassemble to 0xA5C3 MSB-first.
  - s_pen high for cycles 64-65.
  - done pulses at cycle 66.
  - busy is high for cycles 0-65.
- Start re-pulsed at cycles 10 and 40 of a frame with P_Data=16'hFFFF:
  - No restart; still exactly 16 rising edges and one done pulse.
  - Captured word is the value sampled at E0.
- rst pulsed at cycle 20 of a frame:
  - s_clk, s_data, s_pen, busy and done go to 0 immediately (async, before the next clk edge).
  - s_clrn is 0 during reset and 1 on the first clk edge after release.
  - No s_pen pulse occurs; a new Start after reset yields a correct full frame.
- Start held high continuously, P_Data=16'h0001 then 16'h8000:
  - Consecutive frames, each 66 cycles, with done at cycles 66 and 133.
  - Second frame begins on the done edge.
  - Words 0x0001 and 0x8000 are captured correctly.
- HALF=1, DATA_W=8, P_Data=8'h5A:
  - 8 rising edges, one cycle high each; captured 0x5A.
  - s_pen high at cycle 16 only; done at cycle 17.
- P_Data=16'h0000:
  - s_data is 0 on every s_clk rising edge.
  - Frame timing identical to the first scenario.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared state encoding and default geometry for the serial LED
//               chain driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int LED_DATA_W = 16;
    localparam int LED_HALF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } led_state_e;

endpackage
`default_nettype wire

// File: rtl/led_half_tick.sv
`default_nettype none
// ============================================================================
// Module      : led_half_tick
// Description : Half-period counter; o_tick marks the last cycle of each
//               HALF-cycle window, restartable on demand.
// Revision    : 1.0 - initial release
// ============================================================================
module led_half_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                c_cw   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [c_cw-1:0]   c_last = c_cw'(HALF - 1);

    logic [c_cw-1:0] r_cnt;

    assign o_tick = (r_cnt == c_last);

    // Wraps to zero on its own at the tick so consecutive phases chain seamlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_p2s_shifter.sv
`default_nettype none
// ============================================================================
// Module      : led_p2s_shifter
// Description : Serialises a parallel LED word MSB-first onto a 74HC595-style
//               chain with its own shift clock, clear and latch pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_p2s_shifter
    import led_pkg::*;
#(
    parameter int DATA_W = LED_DATA_W,
    parameter int HALF   = LED_HALF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [DATA_W-1:0] P_Data,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_data,
    output logic              s_clrn,
    output logic              s_pen
);

    localparam int              c_bw       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(DATA_W - 1);

    led_state_e        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_sreg, w_sreg_nxt, w_sreg_shl;
    logic [c_bw-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_s_clk, w_s_clk_nxt;
    logic              r_s_data, w_s_data_nxt;
    logic              r_s_pen, w_s_pen_nxt;
    logic              r_s_clrn;
    logic              w_restart;
    logic              w_tick;

    led_half_tick #(
        .HALF      (HALF)
    ) u_half_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_sreg_shl = r_sreg << 1;

    // Output values are computed one cycle ahead so every pin is a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_sreg_nxt    = r_sreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_s_clk_nxt   = r_s_clk;
        w_s_data_nxt  = r_s_data;
        w_s_pen_nxt   = r_s_pen;
        w_restart     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt   = 1'b0;
                w_s_clk_nxt  = 1'b0;
                w_s_pen_nxt  = 1'b0;
                w_s_data_nxt = 1'b0;
                if (Start) begin
                    w_state_nxt   = ST_LOW;
                    w_sreg_nxt    = P_Data;
                    w_bit_cnt_nxt = '0;
                    w_restart     = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_s_data_nxt  = P_Data[DATA_W-1];
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_state_nxt = ST_HIGH;
                    w_s_clk_nxt = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_sreg_nxt  = w_sreg_shl;
                    w_s_clk_nxt = 1'b0;
                    if (r_bit_cnt == c_bit_last) begin
                        w_state_nxt   = ST_LATCH;
                        w_bit_cnt_nxt = '0;
                        w_s_data_nxt  = 1'b0;
                        w_s_pen_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = ST_LOW;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_s_data_nxt  = w_sreg_shl[DATA_W-1];
                    end
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_s_pen_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s_clk   <= 1'b0;
            r_s_data  <= 1'b0;
            r_s_pen   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sreg    <= w_sreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_s_clk   <= w_s_clk_nxt;
            r_s_data  <= w_s_data_nxt;
            r_s_pen   <= w_s_pen_nxt;
        end
    end

    // Chain stays cleared while in reset and is released on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_clrn <= 1'b0;
        end else begin
            r_s_clrn <= 1'b1;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign s_clk  = r_s_clk;
    assign s_data = r_s_data;
    assign s_pen  = r_s_pen;
    assign s_clrn = r_s_clrn;

endmodule
`default_nettype wire

// File: tb/tb_led_p2s_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_p2s_shifter
// Description : Scoreboard bench for two shifter configurations (16b/HALF=2
//               and 8b/HALF=1) with randomized words and handshake noise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_p2s_shifter;

    localparam int D_A = 16;
    localparam int H_A = 2;
    localparam int D_B = 8;
    localparam int H_B = 1;

    typedef struct {
        logic [15:0] word;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a, start_b;
    logic [15:0] pd_a;
    logic [7:0]  pd_b;
    logic        busy_a, done_a, sclk_a, sdata_a, sclrn_a, spen_a;
    logic        busy_b, done_b, sclk_b, sdata_b, sclrn_b, spen_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    led_p2s_shifter #(.DATA_W(D_A), .HALF(H_A)) u_dut_a (
        .clk(clk), .rst(rst), .Start(start_a), .P_Data(pd_a), .busy(busy_a),
        .done(done_a), .s_clk(sclk_a), .s_data(sdata_a), .s_clrn(sclrn_a), .s_pen(spen_a)
    );

    led_p2s_shifter #(.DATA_W(D_B), .HALF(H_B)) u_dut_b (
        .clk(clk), .rst(rst), .Start(start_b), .P_Data(pd_b), .busy(busy_b),
        .done(done_b), .s_clk(sclk_b), .s_data(sdata_b), .s_clrn(sclrn_b), .s_pen(spen_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    initial begin : p_cyc
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: rebuilds each frame from the pins and compares it at done.
    initial begin : p_mon
        bit          m_in[2];
        bit          m_prev_clk[2];
        bit          m_prev_busy[2];
        int          m_start[2], m_edges[2], m_pen[2], m_pen_first[2], m_busy_cnt[2];
        logic [15:0] m_word[2];
        int          d, h;
        logic        b, dn, sc, sd, sp;
        string       tg;
        exp_t        e;
        bit          have;
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 0; m_prev_clk[k] = 0; m_prev_busy[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                d  = (k == 0) ? D_A : D_B;
                h  = (k == 0) ? H_A : H_B;
                b  = (k == 0) ? busy_a  : busy_b;
                dn = (k == 0) ? done_a  : done_b;
                sc = (k == 0) ? sclk_a  : sclk_b;
                sd = (k == 0) ? sdata_a : sdata_b;
                sp = (k == 0) ? spen_a  : spen_b;
                tg = (k == 0) ? "a" : "b";
                if (rst) begin
                    m_in[k] = 0; m_prev_clk[k] = 0; m_prev_busy[k] = 0;
                end else begin
                    if (b && !m_prev_busy[k]) begin
                        m_in[k] = 1; m_start[k] = cyc; m_edges[k] = 0; m_word[k] = '0;
                        m_pen[k] = 0; m_pen_first[k] = -1; m_busy_cnt[k] = 0;
                    end
                    if (m_in[k]) begin
                        if (b) m_busy_cnt[k]++;
                        if (sc && !m_prev_clk[k]) begin
                            m_edges[k]++;
                            m_word[k] = {m_word[k][14:0], sd};
                        end
                        if (sp) begin
                            m_pen[k]++;
                            if (m_pen_first[k] < 0) m_pen_first[k] = cyc - m_start[k];
                        end
                    end
                    if (sp) begin
                        check({tg, ".pen_in_frame"}, 32'(m_in[k]), 32'd1);
                        check({tg, ".pen_sclk_low"}, 32'(sc), 32'd0);
                        check({tg, ".pen_sdata_low"}, 32'(sd), 32'd0);
                    end
                    if (dn) begin
                        check({tg, ".done_in_frame"}, 32'(m_in[k]), 32'd1);
                        check({tg, ".done_busy_low"}, 32'(b), 32'd0);
                        have = (k == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
                        if (!have) begin
                            check({tg, ".done_expected"}, 32'd0, 32'd1);
                        end else begin
                            if (k == 0) e = exp_a.pop_front();
                            else        e = exp_b.pop_front();
                            check({tg, ".word"}, 32'(m_word[k]), 32'(e.word));
                            check({tg, ".start_cycle"}, 32'(m_start[k]), 32'(e.start));
                            check({tg, ".rise_edges"}, 32'(m_edges[k]), 32'(d));
                            check({tg, ".done_cycle"}, 32'(cyc - m_start[k]), 32'(2*h*d + h));
                            check({tg, ".busy_cycles"}, 32'(m_busy_cnt[k]), 32'(2*h*d + h));
                            check({tg, ".pen_first"}, 32'(m_pen_first[k]), 32'(2*h*d));
                            check({tg, ".pen_width"}, 32'(m_pen[k]), 32'(h));
                        end
                        m_in[k] = 0;
                    end
                    m_prev_clk[k]  = sc;
                    m_prev_busy[k] = b;
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge following the accepting edge.
    task automatic issue_a(input logic [15:0] w, input bit noise);
        int t;
        t = 0;
        while (busy_a && t < 300) begin
            @(negedge clk);
            if (noise) begin
                start_a = 1'($urandom_range(0, 1));
                pd_a    = 16'($urandom);
            end
            t++;
        end
        if (t >= 300) begin
            check("a.idle_timeout", 32'd0, 32'd1);
            return;
        end
        start_a = 1'b1;
        pd_a    = w;
        exp_a.push_back('{w, cyc + 1});
        @(negedge clk);
        start_a = 1'b0;
        pd_a    = 16'($urandom);
    endtask

    task automatic issue_b(input logic [7:0] w);
        int t;
        t = 0;
        while (busy_b && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            check("b.idle_timeout", 32'd0, 32'd1);
            return;
        end
        start_b = 1'b1;
        pd_b    = w;
        exp_b.push_back('{{8'h00, w}, cyc + 1});
        @(negedge clk);
        start_b = 1'b0;
        pd_b    = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tg);
        check({tg, ".busy"},   32'(busy_a),  32'd0);
        check({tg, ".done"},   32'(done_a),  32'd0);
        check({tg, ".s_clk"},  32'(sclk_a),  32'd0);
        check({tg, ".s_data"}, 32'(sdata_a), 32'd0);
        check({tg, ".s_pen"},  32'(spen_a),  32'd0);
        check({tg, ".s_clrn"}, 32'(sclrn_a), 32'd0);
    endtask

    task automatic release_reset(input string tg);
        rst = 1'b0;
        #1;
        check({tg, ".clrn_before_edge"}, 32'(sclrn_a), 32'd0);
        @(posedge clk);
        #1;
        check({tg, ".clrn_after_edge"}, 32'(sclrn_a), 32'd1);
        check({tg, ".clrn_b_after_edge"}, 32'(sclrn_b), 32'd1);
        @(negedge clk);
    endtask

    initial begin : p_stim
        int e0;
        int t;
        start_a = 1'b0; pd_a = '0; start_b = 1'b0; pd_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset("por");

        issue_a(16'hA5C3, 1'b0);
        issue_a(16'h0000, 1'b0);

        // Re-pulsed Start mid-frame must neither restart nor queue a frame.
        issue_a(16'hFFFF, 1'b0);
        repeat (9) @(negedge clk);
        start_a = 1'b1; pd_a = 16'h1234;
        @(negedge clk);
        start_a = 1'b0;
        repeat (29) @(negedge clk);
        start_a = 1'b1; pd_a = 16'h0F0F;
        @(negedge clk);
        start_a = 1'b0;

        // Start held high: second frame accepted on the done cycle.
        t = 0;
        while (busy_a && t < 300) begin @(negedge clk); t++; end
        start_a = 1'b1;
        pd_a    = 16'h0001;
        e0      = cyc + 1;
        exp_a.push_back('{16'h0001, e0});
        exp_a.push_back('{16'h8000, e0 + 2*H_A*D_A + H_A + 1});
        @(negedge clk);
        pd_a = 16'h8000;
        t = 0;
        while (cyc < e0 + 2*H_A*D_A + H_A + 1 && t < 300) begin @(negedge clk); t++; end
        start_a = 1'b0;
        pd_a    = 16'($urandom);

        // Asynchronous reset in the middle of a frame.
        issue_a(16'($urandom), 1'b0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_a.delete();
        repeat (2) @(negedge clk);
        release_reset("midrst");
        issue_a(16'($urandom), 1'b0);

        issue_b(8'h5A);
        for (int i = 0; i < 3; i++) issue_b(8'($urandom));

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_a(16'($urandom), 1'b1);
        end

        t = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && t < 1000) begin
            @(negedge clk);
            if (busy_a) start_a = 1'($urandom_range(0, 1));
            else        start_a = 1'b0;
            t++;
        end
        start_a = 1'b0;
        check("drain_timeout", 32'(t < 1000), 32'd1);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
